// File: rtl/switch_led_io.sv
// switch_led_io: switch synchronizer/debouncer and LED register on a memory-mapped window; SWITCH_LED_IO_EVENT_EN adds switch-change event latching.
module switch_led_io #(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0000_1000,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] address,
  input  logic [63:0] write_data,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [63:0] read_data,
  output logic        hit,
  input  logic [17:0] switches,
  output logic [26:0] leds
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [17:0] sync1, sync2, deb, deb_next;
  logic [CW-1:0] cnt [18];
  logic [CW-1:0] cnt_next [18];
  logic [63:0] offset;
  logic [1:0] sel;
  logic wr, rd, unused;
  logic [17:0] evt;
  assign offset = address - BASE_ADDR;
  assign hit = offset < 64'd32 && offset[2:0] == 3'd0;
  assign sel = offset[4:3];
  assign wr = MemWrite && hit;
  assign rd = MemRead && hit;
  assign unused = ^write_data[63:27];
  genvar i;
  generate
    for (i = 0; i < 18; i++) begin : g_deb
      logic differ, accept;
      assign differ = sync2[i] != deb[i];
      assign accept = differ && cnt[i] == LAST;
      assign deb_next[i] = accept ? sync2[i] : deb[i];
      assign cnt_next[i] = (!differ || accept) ? '0 : cnt[i] + 1'b1;
    end
  endgenerate
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      deb <= '0;
      cnt <= '{default: '0};
      leds <= '0;
    end else begin
      sync1 <= switches;
      sync2 <= sync1;
      deb <= deb_next;
      cnt <= cnt_next;
      leds <= (wr && sel == 2'd1) ? write_data[26:0] :
              (wr && sel == 2'd3) ? leds ^ write_data[26:0] : leds;
    end
  end
`ifdef SWITCH_LED_IO_EVENT_EN
  // a bit toggling on the same edge as a clearing read stays set
  always_ff @(posedge clock) begin
    if (reset) evt <= '0;
    else evt <= ((rd && sel == 2'd2) ? '0 : evt) | (deb ^ deb_next);
  end
`else
  assign evt = '0;
`endif
  always_comb begin
    read_data = !hit ? 64'd0 :
                sel == 2'd0 ? {46'd0, deb} :
                sel == 2'd1 ? {37'd0, leds} :
                sel == 2'd2 ? {46'd0, evt} : 64'd0;
  end
endmodule

// File: tb/tb_switch_led_io.sv
// tb_switch_led_io: directed and randomized checks of switch_led_io against a window-based reference model.
module tb_switch_led_io;
  localparam int D = 16;
  localparam logic [63:0] BASE = 64'h1000;
  logic clock = 0, reset = 1;
  logic [63:0] address = 0, write_data = 0, read_data;
  logic MemWrite = 0, MemRead = 0, hit;
  logic [17:0] switches = 0;
  logic [26:0] leds;
  int checks = 0, errors = 0;
  logic [63:0] last_rd;
  logic last_hit;
  logic [17:0] ms1, ms2, mdeb, mevt;
  logic [26:0] mleds;
  logic [17:0] hist[$];

  switch_led_io #(.BASE_ADDR(BASE), .DEBOUNCE_CYCLES(D)) dut (
    .clock(clock), .reset(reset), .address(address), .write_data(write_data),
    .MemWrite(MemWrite), .MemRead(MemRead), .read_data(read_data), .hit(hit),
    .switches(switches), .leds(leds));

  always #5 clock = ~clock;

  function automatic logic in_win(input logic [63:0] a);
    return (a >= BASE) && (a - BASE < 32) && ((a - BASE) % 8 == 0);
  endfunction

  function automatic logic [63:0] exp_read(input logic [63:0] a);
    if (!in_win(a)) return 0;
    case (a - BASE)
      0: return {46'd0, mdeb};
      8: return {37'd0, mleds};
      16: return {46'd0, mevt};
      default: return 0;
    endcase
  endfunction

  // A switch is accepted once its synchronized value has opposed the
  // debounced value for the last D edges in a row.
  always @(posedge clock) begin
    if (reset) begin
      ms1 = 0; ms2 = 0; mdeb = 0; mevt = 0; mleds = 0; hist = {};
    end else begin
      logic [17:0] nd;
      hist.push_back(ms2);
      if (hist.size() > D) void'(hist.pop_front());
      nd = mdeb;
      if (hist.size() == D)
        for (int b = 0; b < 18; b++) begin
          logic all_diff;
          all_diff = 1;
          foreach (hist[j]) if (hist[j][b] == mdeb[b]) all_diff = 0;
          if (all_diff) nd[b] = ~mdeb[b];
        end
`ifdef SWITCH_LED_IO_EVENT_EN
      mevt = ((MemRead && in_win(address) && address - BASE == 16) ? 18'd0 : mevt) | (nd ^ mdeb);
`endif
      if (MemWrite && in_win(address) && address - BASE == 8) mleds = write_data[26:0];
      if (MemWrite && in_win(address) && address - BASE == 24) mleds = mleds ^ write_data[26:0];
      mdeb = nd; ms2 = ms1; ms1 = switches;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // one bus cycle: drive at negedge, compare against model, then take one edge
  task automatic cyc(input logic [63:0] a, input logic r, input logic w, input logic [63:0] d);
    address = a; MemRead = r; MemWrite = w; write_data = d;
    #1;
    last_rd = read_data; last_hit = hit;
    if (!reset) begin
      check("hit", {63'd0, hit}, {63'd0, in_win(a)});
      check("read_data", read_data, exp_read(a));
      check("leds", {37'd0, leds}, {37'd0, mleds});
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    @(negedge clock);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    reset = 0;
    cyc(BASE, 1, 0, 0);       check("rst_sw", last_rd, 0);  check("rst_sw_hit", {63'd0, last_hit}, 1);
    cyc(BASE + 8, 1, 0, 0);   check("rst_led", last_rd, 0);
    cyc(BASE + 16, 1, 0, 0);  check("rst_evt", last_rd, 0); check("rst_evt_hit", {63'd0, last_hit}, 1);
    cyc(BASE + 4, 1, 0, 0);   check("unaligned_hit", {63'd0, last_hit}, 0); check("unaligned_rd", last_rd, 0);
    cyc(BASE + 8, 0, 1, 64'hFFFF_FFFF_0555_5555);
    check("led_store", {37'd0, leds}, 64'h555_5555);
    cyc(BASE + 24, 0, 1, 64'h0000_000F);
    check("led_toggle", {37'd0, leds}, 64'h555_555A);
    cyc(BASE + 8, 1, 0, 0);   check("led_load", last_rd, 64'h555_555A);
    cyc(BASE + 8, 1, 1, 64'h123);
    check("rw_same_pre", last_rd, 64'h555_555A);
    check("rw_same_post", {37'd0, leds}, 64'h123);
    cyc(BASE, 0, 1, 64'h3FFFF); cyc(BASE, 1, 0, 0); check("sw_ro", last_rd, 0);
    switches[3] = 1;
    for (int n = 0; n <= D + 2; n++) begin
      cyc(BASE, 1, 0, 0);
      if (n == D + 1) check("sw3_early", {63'd0, last_rd[3]}, 0);
      if (n == D + 2) check("sw3_accept", {63'd0, last_rd[3]}, 1);
    end
    switches[5] = 1;
    for (int n = 0; n < 10; n++) cyc(BASE, 1, 0, 0);
    switches[5] = 0;
    for (int n = 0; n < D + 6; n++) cyc(BASE, 1, 0, 0);
    check("glitch_sw", last_rd, 64'h8);
`ifdef SWITCH_LED_IO_EVENT_EN
    cyc(BASE + 16, 1, 0, 0); check("evt_sw3", last_rd, 64'h8);
    cyc(BASE + 16, 1, 0, 0); check("evt_cleared", last_rd, 0);
    switches[0] = 1;
    for (int n = 0; n < D + 3; n++) cyc(BASE, 1, 0, 0);
    cyc(BASE + 16, 1, 0, 0); check("evt_sw0", last_rd, 64'h1);
    cyc(BASE + 16, 1, 0, 0); check("evt_sw0_clr", last_rd, 0);
    switches[1] = 1;
    for (int n = 0; n < D + 1; n++) cyc(BASE, 1, 0, 0);
    cyc(BASE + 16, 1, 0, 0); check("evt_race_pre", last_rd, 0);
    cyc(BASE + 16, 1, 0, 0); check("evt_race_set", last_rd, 64'h2);
`endif
    switches[7] = 1;
    for (int n = 0; n < 5; n++) cyc(BASE, 1, 0, 0);
    reset = 1;
    cyc(BASE + 8, 0, 1, 64'h7FF_FFFF);
    reset = 0;
    for (int n = 0; n <= D + 2; n++) begin
      cyc(BASE, 1, 0, 0);
      if (n == 0) check("rst_leds", {37'd0, leds}, 0);
      if (n == D + 1) check("rst_sw7_early", {63'd0, last_rd[7]}, 0);
      if (n == D + 2) check("rst_sw7_accept", {63'd0, last_rd[7]}, 1);
    end
    for (int n = 0; n < 3000; n++) begin
      logic [63:0] a;
      case ($urandom_range(0, 7))
        0: a = BASE;
        1: a = BASE + 8;
        2: a = BASE + 16;
        3: a = BASE + 24;
        4: a = BASE + 64'($urandom_range(1, 31));
        5: a = BASE + 32;
        6: a = BASE - 8;
        default: a = {$urandom, $urandom};
      endcase
      if ($urandom_range(0, 20) == 0) switches[$urandom_range(0, 17)] ^= 1'b1;
      reset = $urandom_range(0, 600) == 0;
      cyc(a, 1'($urandom), 1'($urandom), {$urandom, $urandom});
    end
    reset = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule

// File: doc/switch_led_io.md
# switch_led_io

Memory-mapped I/O peripheral for the pipelined ARMv8 core's data-memory stage. It synchronizes and debounces the board's 18 slide switches, holds the 27-bit LED output register, and optionally latches switch-change events. The memory stage forwards its address, write data and MemRead/MemWrite strobes here and muxes `read_data` back when `hit` is high. `read_data` is combinational from registered state, so it is captured by MEM_WB in the same cycle as a normal data-memory read.

## Interface
- `BASE_ADDR`, 64'h0000_0000_0000_1000: byte address of register 0; the window is 32 bytes.
- `DEBOUNCE_CYCLES`, 16: consecutive cycles a synchronized switch must differ before it is accepted; legal range 1..65535.
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `address`  in  64: byte address from the EX/MEM ALU result.
- `write_data`  in  64: store data from EX/MEM.
- `MemWrite`  in  1: store strobe.
- `MemRead`  in  1: load strobe.
- `read_data`  out  64: combinational load data; zero-extended; 0 when `hit` is low.
- `hit`  out  1: combinational; high when `address` falls inside the window and is 8-byte aligned.
- `switches`  in  18: raw asynchronous board switches.
- `leds`  out  27: LED register, driven directly from a flop.

## Operation
- Register map (offset from `BASE_ADDR`):
  - 0x00 SW: read-only, {46'b0, debounced switches}.
  - 0x08 LED: read/write, {37'b0, leds}.
  - 0x10 EVT: read-to-clear event bits, {46'b0, evt}.
  - 0x18 LED_TGL: write-only (reads 0); `leds <= leds ^ write_data[26:0]`.
- Writes to SW or EVT are ignored. Accesses with `hit` low have no side effects.
- Synchronizer: two flops per switch (`sync1`, `sync2`).
- Debounce: one counter per switch, each `$clog2(DEBOUNCE_CYCLES+1)` bits wide.
  - When `sync2[i] != deb[i]`, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the inputs still differ, `deb[i] <= sync2[i]` and the counter clears.
  - When `sync2[i] == deb[i]`, the counter clears; a glitch restarts the count.
- Events: `evt[i]` is set on the cycle `deb[i]` toggles (either direction).
  - The EVT register is cleared on an edge where `MemRead && hit && offset==0x10`; the load returns the pre-clear value.
  - Set has priority over clear for the same bit on the same edge.
- Simultaneous MemRead and MemWrite to the same offset: the read returns the pre-write value and the write takes effect at the edge.
- Upper `write_data` bits [63:27] are ignored.

## Timing
- Reset values: `sync1`, `sync2`, `deb`, all counters, `evt` and `leds` = 0. `read_data` therefore reads 0 for every register after reset, and `hit` is purely address-decoded.
- Load latency: 0 cycles; `read_data` is valid in the same cycle as `address`/`MemRead`.
- Store latency: `leds` changes on the edge where `MemWrite && hit` is high and is visible on the following cycle.
- Switch latency:
  - A switch stable from before edge k is reflected in SW after edge k+1+DEBOUNCE_CYCLES.
  - The EVT bit is set on that same edge.
- After reset with switches held high, SW reads all-ones after 2+DEBOUNCE_CYCLES edges, and EVT shows those bits set.
- Reset asserted mid-debounce discards the partial count; reset has priority over all writes and clears.
- Counter saturation cannot occur, because the counter clears on accept.

## Configuration
- `SWITCH_LED_IO_EVENT_EN` defined:
  - The `evt` register and its set/clear logic are built.
  - Offset 0x10 behaves as specified above.
- Not defined:
  - No event flops are built.
  - Offset 0x10 reads 0, still asserts `hit`, and has no side effects.
  - All other behaviour is unchanged.

## Test plan
- Reset, then read 0x1000/0x1008/0x1010 -> `read_data` = 0 for each, `hit` = 1; read 0x1004 -> `hit` = 0, `read_data` = 0.
- Store 64'hFFFF_FFFF_0555_5555 to 0x1008 -> `leds` = 27'h555_5555 next cycle; store 27'h000_000F to 0x1018 -> `leds` = 27'h555_555A; load 0x1008 returns 64'h555_555A.
- DEBOUNCE_CYCLES=16: raise `switches[3]` and hold -> SW bit 3 becomes 1 exactly 17 edges after first sampled; a 10-cycle pulse on `switches[5]` -> SW and EVT never change.
- With SWITCH_LED_IO_EVENT_EN: toggle `switches[0]` high, wait for the accept, read 0x1010 -> returns 1 and the next read returns 0. Arrange for `deb[1]` to toggle on the same edge as the clearing read -> the subsequent read returns 2.
- Assert `reset` during a store cycle to 0x1008 and mid-debounce -> `leds` = 0; the debounce restarts and SW updates 2+DEBOUNCE_CYCLES edges after reset deasserts.
